// File: rtl/nx_ram_1r1w_indirect_access_mt.sv
// Multi-table indirect-access wrapper for 1R1W RAMs.
// Software reaches N_TABLES RAMs through one command/status port (READ, WRITE,
// INIT, INIT_INC). Each table keeps its own hardware port, and hardware always
// has priority on its table.
// Ports:
//   clk, rst                       clock, async active-high reset
//   cmnd_valid/op/table_id/addr    one-cycle command strobe and its fields
//   wr_dat                         write/fill data, latched with cmnd_valid
//   stat_code/table_id/addr        registered command status
//   rd_dat                         registered READ result
//   hw_cs/we/re/raddr/waddr/din    per-table hardware access (flattened)
//   hw_dout                        per-table RAM read data (flattened)
//   hw_yield                       asks hardware to release a contended table

// Behavioural 1R1W RAM: active-low strobes, fixed read pipeline.
module nx_ram_1r1w #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned IN_FLOP    = 0,
    parameter int unsigned OUT_FLOP   = 0,
    parameter int unsigned RD_LATENCY = 1,
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             web,
    input  logic             reb,
    input  logic [AW-1:0]    waddr,
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    // Optional input/output flops simply lengthen the read pipeline.
    localparam int unsigned LAT = RD_LATENCY + IN_FLOP + OUT_FLOP;

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] pipe [LAT];

    // Storage array; out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!web && (32'(waddr) < DEPTH)) begin
            mem[waddr] <= din;
        end
    end

    // Read pipeline: stage 0 loads on a read strobe, later stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            if (!reb) begin
                pipe[0] <= (32'(raddr) < DEPTH) ? mem[raddr] : '0;
            end
            for (int i = 1; i < int'(LAT); i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[LAT-1];
endmodule

module nx_ram_1r1w_indirect_access_mt #(
    parameter int unsigned N_TABLES        = 4,
    parameter int unsigned N_ENTRIES       = 256,
    parameter int unsigned N_DATA_BITS     = 32,
    parameter int unsigned N_INIT_INC_BITS = 8,
    parameter int unsigned N_TIMER_BITS    = 6,
    parameter int unsigned RD_LATENCY      = 1,
    localparam int unsigned TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1,
    localparam int unsigned AW = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1,
    localparam int unsigned DW = N_DATA_BITS
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmnd_valid,
    input  logic [3:0]             cmnd_op,
    input  logic [TW-1:0]          cmnd_table_id,
    input  logic [AW-1:0]          cmnd_addr,
    input  logic [DW-1:0]          wr_dat,
    output logic [2:0]             stat_code,
    output logic [TW-1:0]          stat_table_id,
    output logic [AW-1:0]          stat_addr,
    output logic [DW-1:0]          rd_dat,
    input  logic [N_TABLES-1:0]    hw_cs,
    input  logic [N_TABLES-1:0]    hw_we,
    input  logic [N_TABLES-1:0]    hw_re,
    input  logic [N_TABLES*AW-1:0] hw_raddr,
    input  logic [N_TABLES*AW-1:0] hw_waddr,
    input  logic [N_TABLES*DW-1:0] hw_din,
    output logic [N_TABLES*DW-1:0] hw_dout,
    output logic [N_TABLES-1:0]    hw_yield
);
    localparam logic [3:0] OP_NOP      = 4'd0;
    localparam logic [3:0] OP_READ     = 4'd1;
    localparam logic [3:0] OP_WRITE    = 4'd2;
    localparam logic [3:0] OP_INIT     = 4'd4;
    localparam logic [3:0] OP_INIT_INC = 4'd5;

    localparam logic [2:0] ST_RDY  = 3'd0;
    localparam logic [2:0] ST_BUSY = 3'd1;
    localparam logic [2:0] ST_TMO  = 3'd2;
    localparam logic [2:0] ST_ERR  = 3'd3;

    localparam int unsigned RCW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY + 1) : 1;
    localparam logic [RCW-1:0] RD_LAST = RCW'(RD_LATENCY - 1);
    // Abort happens on the (2^N_TIMER_BITS-1)th denied cycle, i.e. when the
    // count of earlier denied cycles equals limit-1.
    localparam logic [N_TIMER_BITS-1:0] TMR_LAST = N_TIMER_BITS'((2 ** N_TIMER_BITS) - 2);
    localparam logic [AW-1:0] IDX_LAST = AW'(N_ENTRIES - 1);
    localparam logic [DW-1:0] INC_MASK = DW'((65'(1) << N_INIT_INC_BITS) - 65'(1));

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_RD_WAIT, S_FILL, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              op_q, op_d;
    logic [TW-1:0]           tid_q, tid_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DW-1:0]           dat_q, dat_d;
    logic [AW-1:0]           idx_q, idx_d;
    logic [N_TIMER_BITS-1:0] timer_q, timer_d;
    logic [RCW-1:0]          rdcnt_q, rdcnt_d;
    logic [2:0]              code_d;
    logic [TW-1:0]           stid_d;
    logic [AW-1:0]           saddr_d;
    logic [DW-1:0]           rd_dat_d;

    logic            sw_we_c, sw_re_c;
    logic            granted, sw_pending;
    logic            cmd_rw, op_legal, cmd_bad;
    logic [AW-1:0]   sw_addr;
    logic [DW-1:0]   sw_din, fill_dat;
    logic [DW-1:0]   ram_dout [N_TABLES];

    // Command decode.
    assign cmd_rw   = (cmnd_op == OP_READ) || (cmnd_op == OP_WRITE);
    assign op_legal = (cmnd_op == OP_NOP) || cmd_rw || (cmnd_op == OP_INIT) ||
                      ((cmnd_op == OP_INIT_INC) && (N_INIT_INC_BITS != 0));
    assign cmd_bad  = !op_legal || (32'(cmnd_table_id) >= N_TABLES) ||
                      (cmd_rw && (32'(cmnd_addr) >= N_ENTRIES));

    // Software owns its table only in cycles where hardware is not selecting it.
    assign sw_pending = (state_q == S_ARB) || (state_q == S_FILL);
    assign granted    = !hw_cs[tid_q];

    // INIT_INC: low field wraps on its own; the carry into upper bits is masked off.
    assign fill_dat = (op_q == OP_INIT_INC) ?
                      ((dat_q & ~INC_MASK) | ((dat_q + DW'(idx_q)) & INC_MASK)) : dat_q;
    assign sw_addr  = (state_q == S_FILL) ? idx_q : addr_q;
    assign sw_din   = (state_q == S_FILL) ? fill_dat : dat_q;

    always_comb begin
        hw_yield = '0;
        if (sw_pending) begin
            hw_yield[tid_q] = hw_cs[tid_q];
        end
    end

    // Next-state and status logic.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tid_d    = tid_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        rdcnt_d  = rdcnt_q;
        code_d   = stat_code;
        stid_d   = stat_table_id;
        saddr_d  = stat_addr;
        rd_dat_d = rd_dat;
        sw_we_c  = 1'b0;
        sw_re_c  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmnd_valid) begin
                    op_d    = cmnd_op;
                    tid_d   = cmnd_table_id;
                    addr_d  = cmnd_addr;
                    dat_d   = wr_dat;
                    idx_d   = '0;
                    timer_d = '0;
                    stid_d  = cmnd_table_id;
                    saddr_d = cmnd_addr;
                    if (cmd_bad) begin
                        code_d = ST_ERR;
                    end else if (cmnd_op == OP_NOP) begin
                        code_d = ST_RDY;
                    end else if (cmd_rw) begin
                        code_d  = ST_BUSY;
                        state_d = S_ARB;
                    end else begin
                        code_d  = ST_BUSY;
                        saddr_d = '0;
                        state_d = S_FILL;
                    end
                end
            end
            S_ARB: begin
                if (granted) begin
                    timer_d = '0;
                    if (op_q == OP_WRITE) begin
                        sw_we_c = 1'b1;
                        code_d  = ST_RDY;
                        saddr_d = addr_q;
                        state_d = S_DONE;
                    end else begin
                        sw_re_c = 1'b1;
                        rdcnt_d = RD_LAST;
                        state_d = S_RD_WAIT;
                    end
                end else if (timer_q == TMR_LAST) begin
                    code_d  = ST_TMO;
                    saddr_d = addr_q;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_RD_WAIT: begin
                if (rdcnt_q == '0) begin
                    rd_dat_d = ram_dout[tid_q];
                    code_d   = ST_RDY;
                    saddr_d  = addr_q;
                    state_d  = S_DONE;
                end else begin
                    rdcnt_d = rdcnt_q - 1'b1;
                end
            end
            S_FILL: begin
                if (granted) begin
                    sw_we_c = 1'b1;
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        code_d  = ST_RDY;
                        saddr_d = idx_q;
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timer_q == TMR_LAST) begin
                    code_d  = ST_TMO;
                    saddr_d = idx_q;
                    timer_d = '0;
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= '0;
            tid_q         <= '0;
            addr_q        <= '0;
            dat_q         <= '0;
            idx_q         <= '0;
            timer_q       <= '0;
            rdcnt_q       <= '0;
            stat_code     <= ST_RDY;
            stat_table_id <= '0;
            stat_addr     <= '0;
            rd_dat        <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            tid_q         <= tid_d;
            addr_q        <= addr_d;
            dat_q         <= dat_d;
            idx_q         <= idx_d;
            timer_q       <= timer_d;
            rdcnt_q       <= rdcnt_d;
            stat_code     <= code_d;
            stat_table_id <= stid_d;
            stat_addr     <= saddr_d;
            rd_dat        <= rd_dat_d;
        end
    end

    // Per-table port mux: hardware passes through, else software, else idle.
    for (genvar t = 0; t < int'(N_TABLES); t++) begin : g_tbl
        logic          web, reb;
        logic [AW-1:0] waddr, raddr;
        logic [DW-1:0] din;

        always_comb begin
            web   = 1'b1;
            reb   = 1'b1;
            waddr = sw_addr;
            raddr = sw_addr;
            din   = sw_din;
            if (hw_cs[t]) begin
                web   = ~hw_we[t];
                reb   = ~hw_re[t];
                waddr = hw_waddr[t*AW +: AW];
                raddr = hw_raddr[t*AW +: AW];
                din   = hw_din[t*DW +: DW];
            end else if (tid_q == TW'(t)) begin
                web = ~sw_we_c;
                reb = ~sw_re_c;
            end
        end

        nx_ram_1r1w #(
            .WIDTH      (DW),
            .DEPTH      (N_ENTRIES),
            .IN_FLOP    (0),
            .OUT_FLOP   (0),
            .RD_LATENCY (RD_LATENCY)
        ) u_ram (
            .clk   (clk),
            .rst_n (~rst),
            .web   (web),
            .reb   (reb),
            .waddr (waddr),
            .raddr (raddr),
            .din   (din),
            .dout  (ram_dout[t])
        );

        assign hw_dout[t*DW +: DW] = ram_dout[t];
    end
endmodule

// File: tb/tb_nx_ram_1r1w_indirect_access_mt.sv
module tb_nx_ram_1r1w_indirect_access_mt;
    localparam int NT = 4;
    localparam int NE = 48;
    localparam int RL = 2;

    localparam logic [3:0] OP_NOP = 4'd0, OP_READ = 4'd1, OP_WRITE = 4'd2,
                           OP_INIT = 4'd4, OP_INIT_INC = 4'd5;
    localparam logic [2:0] ST_RDY = 3'd0, ST_BUSY = 3'd1, ST_TMO = 3'd2, ST_ERR = 3'd3;

    typedef struct packed {
        logic [2:0]  code;
        logic [1:0]  tid;
        logic [5:0]  addr;
        logic [31:0] dat;
        logic [15:0] lat;
    } res_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  tid;
        logic [5:0]  addr;
        logic [31:0] dat;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    logic        cmnd_valid;
    logic [3:0]  cmnd_op;
    logic [1:0]  cmnd_table_id;
    logic [5:0]  cmnd_addr;
    logic [31:0] wr_dat;
    logic [2:0]  stat_code;
    logic [1:0]  stat_table_id;
    logic [5:0]  stat_addr;
    logic [31:0] rd_dat;
    logic [3:0]  hw_cs, hw_we, hw_re, hw_yield;
    logic [23:0] hw_raddr, hw_waddr;
    logic [127:0] hw_din, hw_dout;

    // Second instance: 3 tables of 6 entries so bad table ids are expressible.
    logic        c2_valid;
    logic [3:0]  c2_op;
    logic [1:0]  c2_tid, c2_stid;
    logic [2:0]  c2_addr, c2_saddr, c2_code;
    logic [7:0]  c2_dat, c2_rd;
    logic [2:0]  c2_cs, c2_we, c2_re, c2_yield;
    logic [8:0]  c2_raddr, c2_waddr;
    logic [23:0] c2_din, c2_dout;

    int total = 0;
    int bad   = 0;
    res_t exp_q[$];
    logic [31:0] ref_mem [NT][NE];
    logic [31:0] model_rd;

    always #5 clk = ~clk;

    nx_ram_1r1w_indirect_access_mt #(
        .N_TABLES(NT), .N_ENTRIES(NE), .N_DATA_BITS(32), .N_INIT_INC_BITS(8),
        .N_TIMER_BITS(6), .RD_LATENCY(RL)
    ) dut (
        .clk(clk), .rst(rst), .cmnd_valid(cmnd_valid), .cmnd_op(cmnd_op),
        .cmnd_table_id(cmnd_table_id), .cmnd_addr(cmnd_addr), .wr_dat(wr_dat),
        .stat_code(stat_code), .stat_table_id(stat_table_id), .stat_addr(stat_addr),
        .rd_dat(rd_dat), .hw_cs(hw_cs), .hw_we(hw_we), .hw_re(hw_re),
        .hw_raddr(hw_raddr), .hw_waddr(hw_waddr), .hw_din(hw_din),
        .hw_dout(hw_dout), .hw_yield(hw_yield)
    );

    nx_ram_1r1w_indirect_access_mt #(
        .N_TABLES(3), .N_ENTRIES(6), .N_DATA_BITS(8), .N_INIT_INC_BITS(4),
        .N_TIMER_BITS(4), .RD_LATENCY(1)
    ) dut2 (
        .clk(clk), .rst(rst), .cmnd_valid(c2_valid), .cmnd_op(c2_op),
        .cmnd_table_id(c2_tid), .cmnd_addr(c2_addr), .wr_dat(c2_dat),
        .stat_code(c2_code), .stat_table_id(c2_stid), .stat_addr(c2_saddr),
        .rd_dat(c2_rd), .hw_cs(c2_cs), .hw_we(c2_we), .hw_re(c2_re),
        .hw_raddr(c2_raddr), .hw_waddr(c2_waddr), .hw_din(c2_din),
        .hw_dout(c2_dout), .hw_yield(c2_yield)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: computes the expected status and updates model state.
    task automatic model_cmd(input logic [3:0] op, input logic [1:0] tid,
                             input logic [5:0] addr, input logic [31:0] dat,
                             input int extra, output res_t e);
        logic illegal;
        logic [7:0] lo;
        illegal = !(op inside {OP_NOP, OP_READ, OP_WRITE, OP_INIT, OP_INIT_INC}) ||
                  ((op == OP_READ || op == OP_WRITE) && int'(addr) >= NE);
        e.tid  = tid;
        e.addr = addr;
        if (illegal) begin
            e.code = ST_ERR;
            e.lat  = 16'd1;
        end else begin
            e.code = ST_RDY;
            case (op)
                OP_NOP: e.lat = 16'd1;
                OP_WRITE: begin
                    ref_mem[tid][addr] = dat;
                    e.lat = 16'(2 + extra);
                end
                OP_READ: begin
                    model_rd = ref_mem[tid][addr];
                    e.lat = 16'(2 + RL + extra);
                end
                default: begin
                    for (int i = 0; i < NE; i++) begin
                        lo = dat[7:0] + 8'(i);
                        ref_mem[tid][i] = (op == OP_INIT_INC) ? {dat[31:8], lo} : dat;
                    end
                    e.addr = 6'(NE - 1);
                    e.lat  = 16'(NE + 1 + extra);
                end
            endcase
        end
        e.dat = model_rd;
    endtask

    // Drives one command and waits (bounded) for the final status.
    task automatic run_cmd(input logic [3:0] op, input logic [1:0] tid,
                           input logic [5:0] addr, input logic [31:0] dat,
                           output res_t r);
        int lat;
        cmnd_valid = 1'b1; cmnd_op = op; cmnd_table_id = tid;
        cmnd_addr = addr;  wr_dat = dat;
        tick();
        cmnd_valid = 1'b0;
        lat = 1;
        while (stat_code == ST_BUSY && lat < 300) begin
            tick();
            lat++;
        end
        r = '{code: stat_code, tid: stat_table_id, addr: stat_addr, dat: rd_dat, lat: 16'(lat)};
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        total++; if (stat_code !== ST_RDY) begin bad++; $display("FAIL reset_code: got %0d want 0", stat_code); end
        total++; if (stat_table_id !== 2'd0) begin bad++; $display("FAIL reset_tid: got %0d want 0", stat_table_id); end
        total++; if (stat_addr !== 6'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", stat_addr); end
        total++; if (rd_dat !== 32'd0) begin bad++; $display("FAIL reset_rd_dat: got %h want 0", rd_dat); end
        total++; if (hw_yield !== 4'd0) begin bad++; $display("FAIL reset_yield: got %b want 0", hw_yield); end
        total++; if (c2_code !== ST_RDY) begin bad++; $display("FAIL reset_code2: got %0d want 0", c2_code); end
        rst = 1'b0;
        model_rd = '0;
        tick();
    endtask

    task automatic test_write_read();
        cmd_t cmds [8];
        res_t e, r;
        cmds = '{'{OP_WRITE, 2'd2, 6'h10, 32'hDEADBEEF}, '{OP_READ, 2'd2, 6'h10, 32'h0},
                 '{OP_WRITE, 2'd0, 6'd5, 32'h0BADF00D},  '{OP_WRITE, 2'd3, 6'd47, 32'hFFFFFFFF},
                 '{OP_READ, 2'd0, 6'd5, 32'h0},          '{OP_READ, 2'd3, 6'd47, 32'h0},
                 '{OP_WRITE, 2'd1, 6'd0, $urandom},      '{OP_READ, 2'd1, 6'd0, 32'h0}};
        for (int i = 0; i < 8; i++) begin
            model_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, 0, e);
            exp_q.push_back(e);
            run_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, r);
            e = exp_q.pop_front();
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL write_read[%0d]: got code=%0d tid=%0d addr=%0d dat=%h lat=%0d, want code=%0d tid=%0d addr=%0d dat=%h lat=%0d",
                         i, r.code, r.tid, r.addr, r.dat, r.lat, e.code, e.tid, e.addr, e.dat, e.lat);
            end
        end
    endtask

    task automatic test_init();
        cmd_t cmds [7];
        res_t e, r;
        cmds = '{'{OP_INIT_INC, 2'd0, 6'd0, 32'hAB0000FE}, '{OP_READ, 2'd0, 6'd0, 32'h0},
                 '{OP_READ, 2'd0, 6'd1, 32'h0},            '{OP_READ, 2'd0, 6'd2, 32'h0},
                 '{OP_READ, 2'd0, 6'd47, 32'h0},           '{OP_INIT, 2'd1, 6'd9, 32'h12345678},
                 '{OP_READ, 2'd1, 6'd33, 32'h0}};
        for (int i = 0; i < 7; i++) begin
            model_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, 0, e);
            exp_q.push_back(e);
            run_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, r);
            e = exp_q.pop_front();
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL init[%0d]: got code=%0d tid=%0d addr=%0d dat=%h lat=%0d, want code=%0d tid=%0d addr=%0d dat=%h lat=%0d",
                         i, r.code, r.tid, r.addr, r.dat, r.lat, e.code, e.tid, e.addr, e.dat, e.lat);
            end
        end
    endtask

    task automatic test_contention();
        res_t e, r;
        int lat, yc, oth;
        model_cmd(OP_READ, 2'd1, 6'd7, 32'h0, 5, e);
        exp_q.push_back(e);
        cmnd_valid = 1'b1; cmnd_op = OP_READ; cmnd_table_id = 2'd1; cmnd_addr = 6'd7;
        tick();
        cmnd_valid = 1'b0;
        yc = 0; oth = 0;
        // Hardware holds table 1 and writes table 0 during the same window.
        for (int k = 1; k <= 5; k++) begin
            hw_cs = 4'b0011; hw_we = 4'b0001;
            hw_waddr[5:0] = 6'(20 + k);
            hw_din[31:0]  = 32'h01010101 * k;
            ref_mem[0][20 + k] = 32'h01010101 * k;
            #1;
            if (hw_yield[1]) yc++;
            if ((hw_yield & 4'b1101) != 4'b0) oth++;
            tick();
        end
        hw_cs = '0; hw_we = '0;
        lat = 6;
        while (stat_code == ST_BUSY && lat < 300) begin
            tick();
            lat++;
        end
        r = '{code: stat_code, tid: stat_table_id, addr: stat_addr, dat: rd_dat, lat: 16'(lat)};
        tick();
        e = exp_q.pop_front();
        total++;
        if (r !== e) begin
            bad++;
            $display("FAIL contention_read: got code=%0d tid=%0d addr=%0d dat=%h lat=%0d, want code=%0d tid=%0d addr=%0d dat=%h lat=%0d",
                     r.code, r.tid, r.addr, r.dat, r.lat, e.code, e.tid, e.addr, e.dat, e.lat);
        end
        total++; if (yc != 5) begin bad++; $display("FAIL yield_cycles: got %0d want 5", yc); end
        total++; if (oth != 0) begin bad++; $display("FAIL yield_other: got %0d want 0", oth); end
        for (int k = 1; k <= 5; k++) begin
            hw_cs = 4'b0001; hw_re = 4'b0001; hw_raddr[5:0] = 6'(20 + k);
            tick();
            hw_cs = '0; hw_re = '0;
            tick();
            total++;
            if (hw_dout[31:0] !== ref_mem[0][20 + k]) begin
                bad++;
                $display("FAIL hw_read[%0d]: got %h want %h", 20 + k, hw_dout[31:0], ref_mem[0][20 + k]);
            end
        end
    endtask

    task automatic test_timeout();
        res_t e, r;
        int lat;
        model_cmd(OP_WRITE, 2'd3, 6'd9, 32'h99, 0, e);
        run_cmd(OP_WRITE, 2'd3, 6'd9, 32'h99, r);
        total++; if (r !== e) begin bad++; $display("FAIL tmo_prewrite: got code=%0d lat=%0d want code=%0d lat=%0d", r.code, r.lat, e.code, e.lat); end
        hw_cs = 4'b1000;
        exp_q.push_back('{code: ST_TMO, tid: 2'd3, addr: 6'd9, dat: model_rd, lat: 16'd64});
        cmnd_valid = 1'b1; cmnd_op = OP_WRITE; cmnd_table_id = 2'd3; cmnd_addr = 6'd9; wr_dat = 32'h77;
        tick();
        cmnd_valid = 1'b0;
        total++; if (hw_yield !== 4'b1000) begin bad++; $display("FAIL tmo_yield_on: got %b want 1000", hw_yield); end
        lat = 1;
        while (stat_code == ST_BUSY && lat < 300) begin
            tick();
            lat++;
        end
        r = '{code: stat_code, tid: stat_table_id, addr: stat_addr, dat: rd_dat, lat: 16'(lat)};
        e = exp_q.pop_front();
        total++;
        if (r !== e) begin
            bad++;
            $display("FAIL timeout: got code=%0d tid=%0d addr=%0d lat=%0d, want code=%0d tid=%0d addr=%0d lat=%0d",
                     r.code, r.tid, r.addr, r.lat, e.code, e.tid, e.addr, e.lat);
        end
        total++; if (hw_yield !== 4'b0000) begin bad++; $display("FAIL tmo_yield_off: got %b want 0000", hw_yield); end
        while (lat < 70) begin
            tick();
            lat++;
        end
        hw_cs = '0;
        tick();
        // Aborted write must leave the old value; the next command is accepted.
        model_cmd(OP_READ, 2'd3, 6'd9, 32'h0, 0, e);
        run_cmd(OP_READ, 2'd3, 6'd9, 32'h0, r);
        total++; if (r !== e) begin bad++; $display("FAIL tmo_after_read: got dat=%h lat=%0d want dat=%h lat=%0d", r.dat, r.lat, e.dat, e.lat); end
        model_cmd(OP_WRITE, 2'd3, 6'd9, 32'h77, 0, e);
        run_cmd(OP_WRITE, 2'd3, 6'd9, 32'h77, r);
        model_cmd(OP_READ, 2'd3, 6'd9, 32'h0, 0, e);
        run_cmd(OP_READ, 2'd3, 6'd9, 32'h0, r);
        total++; if (r !== e) begin bad++; $display("FAIL tmo_rewrite: got dat=%h lat=%0d want dat=%h lat=%0d", r.dat, r.lat, e.dat, e.lat); end
    endtask

    task automatic test_illegal();
        cmd_t cmds [7];
        res_t e, r;
        cmds = '{'{OP_WRITE, 2'd2, 6'd4, 32'h11111111}, '{4'd7, 2'd2, 6'd4, 32'h55},
                 '{4'd3, 2'd2, 6'd4, 32'h66},            '{OP_READ, 2'd1, 6'd48, 32'h0},
                 '{OP_WRITE, 2'd2, 6'd50, 32'h77},       '{OP_NOP, 2'd1, 6'd3, 32'h0},
                 '{OP_READ, 2'd2, 6'd4, 32'h0}};
        for (int i = 0; i < 7; i++) begin
            model_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, 0, e);
            exp_q.push_back(e);
            run_cmd(cmds[i].op, cmds[i].tid, cmds[i].addr, cmds[i].dat, r);
            e = exp_q.pop_front();
            total++;
            if (r !== e) begin
                bad++;
                $display("FAIL illegal[%0d]: got code=%0d tid=%0d addr=%0d dat=%h lat=%0d, want code=%0d tid=%0d addr=%0d dat=%h lat=%0d",
                         i, r.code, r.tid, r.addr, r.dat, r.lat, e.code, e.tid, e.addr, e.dat, e.lat);
            end
        end
        // Table id equal to the table count on the 3-table instance.
        c2_valid = 1'b1; c2_op = OP_READ; c2_tid = 2'd3; c2_addr = 3'd1;
        tick();
        c2_valid = 1'b0;
        total++; if (c2_code !== ST_ERR) begin bad++; $display("FAIL bad_table: got %0d want 3", c2_code); end
        tick();
        c2_valid = 1'b1; c2_op = OP_WRITE; c2_tid = 2'd0; c2_addr = 3'd6; c2_dat = 8'h5A;
        tick();
        c2_valid = 1'b0;
        total++; if (c2_code !== ST_ERR) begin bad++; $display("FAIL bad_addr2: got %0d want 3", c2_code); end
        tick();
        c2_valid = 1'b1; c2_op = OP_WRITE; c2_tid = 2'd2; c2_addr = 3'd5;
        tick();
        c2_valid = 1'b0;
        total++; if (c2_code !== ST_BUSY) begin bad++; $display("FAIL c2_busy: got %0d want 1", c2_code); end
        tick();
        total++; if (c2_code !== ST_RDY || c2_saddr !== 3'd5) begin bad++; $display("FAIL c2_write: got code=%0d addr=%0d want code=0 addr=5", c2_code, c2_saddr); end
        tick();
    endtask

    task automatic test_reset_mid_fill();
        res_t e, r;
        cmnd_valid = 1'b1; cmnd_op = OP_INIT; cmnd_table_id = 2'd1; cmnd_addr = '0; wr_dat = 32'hCAFE0000;
        tick();
        cmnd_valid = 1'b0;
        for (int k = 1; k < 31; k++) tick();
        total++; if (stat_code !== ST_BUSY) begin bad++; $display("FAIL fill_busy: got %0d want 1", stat_code); end
        rst = 1'b1;
        #1;
        total++;
        if (stat_code !== ST_RDY || stat_table_id !== 2'd0 || stat_addr !== 6'd0 || rd_dat !== 32'd0 || hw_yield !== 4'd0) begin
            bad++;
            $display("FAIL mid_fill_reset: got code=%0d tid=%0d addr=%0d dat=%h yield=%b want all zero",
                     stat_code, stat_table_id, stat_addr, rd_dat, hw_yield);
        end
        tick(); tick();
        rst = 1'b0;
        model_rd = '0;
        for (int i = 0; i < NE; i++) ref_mem[1][i] = 'x;
        tick();
        model_cmd(OP_WRITE, 2'd1, 6'd2, 32'h0000600D, 0, e);
        run_cmd(OP_WRITE, 2'd1, 6'd2, 32'h0000600D, r);
        total++; if (r !== e) begin bad++; $display("FAIL post_reset_write: got code=%0d lat=%0d want code=%0d lat=%0d", r.code, r.lat, e.code, e.lat); end
        model_cmd(OP_READ, 2'd1, 6'd2, 32'h0, 0, e);
        run_cmd(OP_READ, 2'd1, 6'd2, 32'h0, r);
        total++; if (r !== e) begin bad++; $display("FAIL post_reset_read: got dat=%h lat=%0d want dat=%h lat=%0d", r.dat, r.lat, e.dat, e.lat); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cmnd_valid = 1'b0; cmnd_op = '0; cmnd_table_id = '0; cmnd_addr = '0; wr_dat = '0;
        hw_cs = '0; hw_we = '0; hw_re = '0; hw_raddr = '0; hw_waddr = '0; hw_din = '0;
        c2_valid = 1'b0; c2_op = '0; c2_tid = '0; c2_addr = '0; c2_dat = '0;
        c2_cs = '0; c2_we = '0; c2_re = '0; c2_raddr = '0; c2_waddr = '0; c2_din = '0;
        model_rd = '0;
        test_reset();
        test_write_read();
        test_init();
        test_contention();
        test_timeout();
        test_illegal();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nx_ram_1r1w_indirect_access_mt.md
# nx_ram_1r1w_indirect_access_mt

Multi-table indirect-access wrapper for 1R1W RAMs. Gives software access to N_TABLES independent nx_ram_1r1w instances through one command/status port, while each table keeps its own hardware read/write port. Beyond single-table read/write it adds whole-table INIT and INIT_INC fill, a per-command arbitration timeout, and a per-table hw_yield request. It sits between the CSR decode logic and the datapath tables of an engine.

## Interface
- N_TABLES, 4: number of RAM tables (1..16).
- N_ENTRIES, 256: depth of each table (≥2).
- N_DATA_BITS, 32: word width.
- N_INIT_INC_BITS, 8: low bits incremented by INIT_INC (0 disables INIT_INC; must be ≤ N_DATA_BITS).
- N_TIMER_BITS, 6: width of the arbitration timeout counter; limit is 2^N_TIMER_BITS-1.
- RD_LATENCY, 1: RAM read latency in cycles (≥1), passed to nx_ram_1r1w; IN_FLOP=OUT_FLOP=0.
- clk  in  1  the single clock.
- rst  in  1  asynchronous, active-high reset; drives nx_ram_1r1w rst_n via inversion.
- cmnd_valid  in  1  one-cycle command strobe.
- cmnd_op  in  4  0 NOP, 1 READ, 2 WRITE, 4 INIT, 5 INIT_INC; all others illegal.
- cmnd_table_id  in  log2(N_TABLES)  target table.
- cmnd_addr  in  log2(N_ENTRIES)  target entry for READ/WRITE.
- wr_dat  in  N_DATA_BITS  write/fill data; latched with cmnd_valid.
- stat_code  out  3  0 RDY, 1 BUSY, 2 TMO, 3 ERR.
- stat_table_id  out  log2(N_TABLES)  table of the last command.
- stat_addr  out  log2(N_ENTRIES)  address of the last access, or the abort point.
- rd_dat  out  N_DATA_BITS  READ result.
- hw_cs, hw_we, hw_re  in  N_TABLES each  per-table hardware strobes.
- hw_raddr, hw_waddr  in  N_TABLES*log2(N_ENTRIES)  flattened addresses; table t occupies slice t.
- hw_din  in  N_TABLES*N_DATA_BITS  flattened write data.
- hw_dout  out  N_TABLES*N_DATA_BITS  flattened RAM read data.
- hw_yield  out  N_TABLES  request for hardware to release table t.

## Operation
- FSM states: IDLE, ARB, RD_WAIT, FILL, DONE.
- Command acceptance: cmnd_valid is accepted only in IDLE. In other states it is ignored and status is left unchanged.
- Decode in IDLE:
  - Illegal op, cmnd_table_id ≥ N_TABLES, cmnd_addr ≥ N_ENTRIES on READ/WRITE, or INIT_INC with N_INIT_INC_BITS=0 → stat ERR, stay IDLE.
  - NOP → stat RDY.
  - READ/WRITE → ARB.
  - INIT/INIT_INC → FILL with fill index 0.
- Grant rule: hardware has absolute priority. Software owns table t in a cycle only when hw_cs[t]=0. Other tables are never affected.
- ARB: issues the access on the first granted cycle.
  - WRITE → DONE.
  - READ → RD_WAIT; after RD_LATENCY cycles, RAM dout is captured into rd_dat, then DONE.
- FILL: writes index i on each granted cycle and increments i; after index N_ENTRIES-1 → DONE.
  - INIT writes wr_dat.
  - INIT_INC writes wr_dat with bits [N_INIT_INC_BITS-1:0] replaced by (wr_dat low bits + i) mod 2^N_INIT_INC_BITS; upper bits are unchanged.
- Timer: counts consecutive denied cycles in ARB/FILL and clears on each grant. At the limit, the command aborts: stat TMO, stat_addr = pending address, FSM → IDLE. Writes already done by FILL stay in the RAM.
- hw_yield[t]=1 while FSM is in ARB/FILL for table t and that cycle is denied; 0 otherwise.
- DONE: stat RDY, stat_addr = last address accessed → IDLE.
- Mux into RAM t:
  - hw_cs[t]=1: hardware signals pass through.
  - Software active on t: web/reb driven from the FSM.
  - Otherwise: web=reb=1.

## Timing
- Reset values: stat_code=RDY, stat_table_id=0, stat_addr=0, rd_dat=0, hw_yield=0, FSM IDLE, timer 0.
- hw_dout follows RAM dout and is not reset by this block.
- stat_code, stat_table_id, stat_addr and rd_dat are registered. stat_code=BUSY from the cycle after acceptance until completion.
- Uncontested latencies, with cmnd_valid at cycle 0:
  - WRITE: RAM write at cycle 1, RDY at cycle 2.
  - READ: issue at cycle 1, rd_dat and RDY valid at cycle 2+RD_LATENCY.
  - INIT/INIT_INC: writes at cycles 1..N_ENTRIES, RDY at N_ENTRIES+1.
  - ERR and NOP: status at cycle 1.
- Each denied cycle adds one cycle of latency.
- A timeout occurs on the 2^N_TIMER_BITS-1th consecutive denied cycle; TMO is visible the next cycle.
- Reset mid-FILL aborts immediately; partial table contents are undefined-but-written.
- Hardware and software hitting the same address in the same cycle: hardware wins, software waits.

## Test plan
- WRITE table 2 addr 0x10 data 0xDEADBEEF, then READ with RD_LATENCY=2 → RDY at cycle 2, rd_dat=0xDEADBEEF at cycle 4, stat_table_id=2, stat_addr=0x10.
- INIT_INC table 0 with wr_dat=0xAB0000FE, N_INIT_INC_BITS=8 → entry 0=0xAB0000FE, entry 1=0xAB0000FF, entry 2=0xAB000000; RDY at cycle N_ENTRIES+1.
- READ table 1 with hw_cs[1] held high for 5 cycles → hw_yield[1]=1 for 5 cycles; access issued on cycle 6; other tables' hardware traffic undisturbed.
- hw_cs[3] held high for 70 cycles with N_TIMER_BITS=6 → stat TMO after 63 denied cycles; hw_yield[3] drops; subsequent command accepted.
- Illegal op 7, table_id=N_TABLES, addr=N_ENTRIES → stat ERR at cycle 1 each; no RAM write occurs.
- Assert rst during INIT at index 100 → all outputs at reset values; new WRITE after release completes normally.
